// File: rtl/seq_lock_checker_pkg.sv
// lock_pkg: shared states, segment codes, default code and sizing helpers for seq_lock_checker.
package lock_pkg;
  typedef enum logic [2:0] {ST_CHECK, ST_DONE_S, ST_DONE_P, ST_FAIL, ST_PROG} state_t;
  localparam logic [6:0] SEG_S    = 7'h6D;
  localparam logic [6:0] SEG_P    = 7'h73;
  localparam logic [6:0] SEG_F    = 7'h71;
  localparam logic [6:0] SEG_E    = 7'h79;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [3:0] DEFAULT_CODE [6] = '{4'd5, 4'd9, 4'd0, 4'd0, 4'd6, 4'd0};
  // Shorter or longer codes reuse the pattern from its first digit onward.
  function automatic logic [3:0] default_digit(input int i);
    return DEFAULT_CODE[i % 6];
  endfunction
  function automatic int err_w(input int max_err);
    return (max_err < 1) ? 1 : $clog2(max_err + 1);
  endfunction
endpackage

// File: rtl/seq_lock_checker_if.sv
// seq_lock_checker_if: keypad strobes in, display/status out.
interface seq_lock_checker_if #(parameter int DIGIT_W = 4);
  logic               insere;
  logic [DIGIT_W-1:0] entrada;
  logic               limpa;
  logic               programa;
  logic [6:0]         display1;
  logic               led;
  logic               bloqueado;
  modport master(output insere, entrada, limpa, programa, input display1, led, bloqueado);
  modport slave(input insere, entrada, limpa, programa, output display1, led, bloqueado);
endinterface

// File: rtl/seq_lock_checker_seg7_hex.sv
// seg7_hex: 4-bit hex digit to active-high {g,f,e,d,c,b,a} segments.
module seg7_hex (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  assign seg = HEX[d];
endmodule

// File: rtl/seq_lock_checker.sv
// seq_lock_checker: digit-sequence lock with error tolerance, timed lockout and reprogramming.
module seq_lock_checker
  import lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 6,
  parameter int MAX_ERR     = 1,
  parameter int LOCKOUT_CYC = 16
) (
  input logic clk,
  input logic reset,
  seq_lock_checker_if.slave bus
);
  localparam int PW = $clog2(CODE_LEN);
  localparam int EW = err_w(MAX_ERR);
  localparam int CW = $clog2(LOCKOUT_CYC + 1);
  state_t             state, state_n;
  logic [PW-1:0]      pos, pos_n;
  logic [EW-1:0]      err, err_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [6:0]         disp, disp_n, hex_seg;
  logic               led_r, led_n, blk, blk_n, we, hit, last;
  logic [DIGIT_W-1:0] code [CODE_LEN];
  seg7_hex u_hex (.d(4'(bus.entrada)), .seg(hex_seg));
  assign hit           = bus.entrada == code[pos];
  assign last          = pos == PW'(CODE_LEN - 1);
  assign bus.display1  = disp;
  assign bus.led       = led_r;
  assign bus.bloqueado = blk;
  always_comb begin
    state_n = state;
    pos_n   = pos;
    err_n   = err;
    cnt_n   = cnt;
    disp_n  = disp;
    led_n   = led_r;
    blk_n   = blk;
    we      = 1'b0;
    if (state == ST_FAIL) begin
      cnt_n = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state_n = ST_CHECK;
        pos_n   = '0;
        err_n   = '0;
        disp_n  = SEG_DASH;
        blk_n   = 1'b0;
      end
    end else if (bus.limpa) begin
      state_n = ST_CHECK;
      pos_n   = '0;
      err_n   = '0;
      disp_n  = SEG_DASH;
      led_n   = 1'b0;
    end else if (bus.programa && state == ST_DONE_S) begin
      state_n = ST_PROG;
      pos_n   = '0;
      disp_n  = SEG_DASH;
      led_n   = 1'b0;
    end else if (bus.insere && state == ST_CHECK) begin
      if (hit && last) begin
        state_n = (err == '0) ? ST_DONE_S : ST_DONE_P;
        disp_n  = (err == '0) ? SEG_S : SEG_P;
        led_n   = 1'b1;
      end else if (hit) begin
        pos_n  = pos + 1'b1;
        disp_n = hex_seg;
      end else if (err < EW'(MAX_ERR)) begin
        err_n  = err + 1'b1;
        disp_n = SEG_E;
      end else begin
        state_n = ST_FAIL;
        disp_n  = SEG_F;
        blk_n   = 1'b1;
        cnt_n   = CW'(LOCKOUT_CYC);
      end
    end else if (bus.insere && state == ST_PROG) begin
      we      = 1'b1;
      pos_n   = last ? '0 : pos + 1'b1;
      err_n   = '0;
      state_n = last ? ST_CHECK : ST_PROG;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CHECK;
      pos   <= '0;
      err   <= '0;
      cnt   <= '0;
      disp  <= SEG_DASH;
      led_r <= 1'b0;
      blk   <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) code[i] <= DIGIT_W'(default_digit(i));
    end else begin
      state <= state_n;
      pos   <= pos_n;
      err   <= err_n;
      cnt   <= cnt_n;
      disp  <= disp_n;
      led_r <= led_n;
      blk   <= blk_n;
      if (we) code[pos] <= bus.entrada;
    end
  end
endmodule

// File: tb/tb_seq_lock_checker.sv
// tb_seq_lock_checker: directed vectors with a queued scoreboard on two parameterisations.
module tb_seq_lock_checker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  seq_lock_checker_if #(.DIGIT_W(4)) a_if ();
  seq_lock_checker_if #(.DIGIT_W(8)) b_if ();
  seq_lock_checker u_a (.clk(clk), .reset(reset), .bus(a_if));
  seq_lock_checker #(.DIGIT_W(8), .CODE_LEN(3), .MAX_ERR(0), .LOCKOUT_CYC(3))
    u_b (.clk(clk), .reset(reset), .bus(b_if));
  typedef struct {
    bit         sel;
    logic [6:0] disp;
    logic       led;
    logic       blk;
    string      nm;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_miss = 0;
  // Outputs are compared on the falling edge, half a cycle after they update.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = e.sel ? {b_if.display1, b_if.led, b_if.bloqueado} : {a_if.display1, a_if.led, a_if.bloqueado};
      n_vec++;
      if (got !== {e.disp, e.led, e.blk}) begin
        n_miss++;
        $display("FAIL %s (dut %0d): got disp=%h led=%b blk=%b, want disp=%h led=%b blk=%b",
                 e.nm, e.sel, got[8:2], got[1], got[0], e.disp, e.led, e.blk);
      end
    end
  end
  task automatic idle_inputs();
    a_if.insere = 0; a_if.entrada = '0; a_if.limpa = 0; a_if.programa = 0;
    b_if.insere = 0; b_if.entrada = '0; b_if.limpa = 0; b_if.programa = 0;
  endtask
  task automatic step(input bit sel, input bit ins, input logic [7:0] d, input bit lim, input bit prg,
                      input logic [6:0] disp, input bit led, input bit blk, input string nm);
    @(negedge clk);
    if (sel) begin
      b_if.insere = ins; b_if.entrada = d; b_if.limpa = lim; b_if.programa = prg;
    end else begin
      a_if.insere = ins; a_if.entrada = d[3:0]; a_if.limpa = lim; a_if.programa = prg;
    end
    @(posedge clk);
    #1;
    q.push_back('{sel: sel, disp: disp, led: led, blk: blk, nm: nm});
    idle_inputs();
  endtask
  task automatic dig(input bit sel, input logic [7:0] d, input logic [6:0] disp, input string nm);
    step(sel, 1, d, 0, 0, disp, 0, 0, nm);
  endtask
  task automatic def_unlock(input string nm);
    dig(0, 5, 7'h6D, nm); dig(0, 9, 7'h6F, nm); dig(0, 0, 7'h3F, nm);
    dig(0, 0, 7'h3F, nm); dig(0, 6, 7'h7D, nm);
    step(0, 1, 0, 0, 0, 7'h6D, 1, 0, {nm, "_S"});
  endtask
  // Lockout of n cycles: the failing step already showed one; strobes/clear/program are ignored.
  task automatic lock_wait(input bit sel, input int n, input string nm);
    for (int i = 1; i < n; i++) step(sel, 1, 5, i[0], i[1], 7'h71, 0, 1, nm);
    step(sel, 1, 5, 1, 0, 7'h40, 0, 0, {nm, "_end"});
  endtask
  task automatic areset(input string nm);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 0;
    #1 q.push_back('{sel: 0, disp: 7'h40, led: 0, blk: 0, nm: nm});
    @(negedge clk);
    #1 reset = 1;
  endtask
  initial begin
    idle_inputs();
    #2;
    q.push_back('{sel: 0, disp: 7'h40, led: 0, blk: 0, nm: "reset_a"});
    q.push_back('{sel: 1, disp: 7'h40, led: 0, blk: 0, nm: "reset_b"});
    @(negedge clk);
    #1 reset = 1;
    def_unlock("unlock");
    step(0, 1, 3, 0, 0, 7'h6D, 1, 0, "done_ignores_insere");
    step(0, 0, 0, 1, 0, 7'h40, 0, 0, "limpa_from_s");
    dig(0, 5, 7'h6D, "p_5"); dig(0, 8, 7'h79, "p_err");
    dig(0, 9, 7'h6F, "p_9"); dig(0, 0, 7'h3F, "p_0"); dig(0, 0, 7'h3F, "p_0b");
    dig(0, 6, 7'h7D, "p_6");
    step(0, 1, 0, 0, 0, 7'h73, 1, 0, "partial_P");
    step(0, 0, 0, 0, 1, 7'h73, 1, 0, "prog_ignored_in_P");
    step(0, 0, 0, 1, 0, 7'h40, 0, 0, "limpa_from_p");
    dig(0, 5, 7'h6D, "f_5"); dig(0, 8, 7'h79, "f_err1");
    step(0, 1, 8, 0, 0, 7'h71, 0, 1, "fail_F");
    lock_wait(0, 16, "lockout16");
    dig(0, 5, 7'h6D, "after_lock_pos0");
    step(0, 0, 0, 1, 0, 7'h40, 0, 0, "limpa_after_lock");
    def_unlock("pre_prog");
    step(0, 0, 0, 0, 1, 7'h40, 0, 0, "enter_prog");
    for (int i = 1; i <= 6; i++) step(0, 1, 8'(i), 0, 0, 7'h40, 0, 0, "prog_write");
    dig(0, 5, 7'h79, "old_code_err");
    step(0, 1, 9, 0, 0, 7'h71, 0, 1, "old_code_fail");
    lock_wait(0, 16, "lockout_prog");
    dig(0, 1, 7'h06, "new_1"); dig(0, 2, 7'h5B, "new_2"); dig(0, 3, 7'h4F, "new_3");
    dig(0, 4, 7'h66, "new_4"); dig(0, 5, 7'h6D, "new_5");
    step(0, 1, 6, 0, 0, 7'h6D, 1, 0, "new_code_S");
    step(0, 0, 0, 1, 0, 7'h40, 0, 0, "limpa_new");
    dig(0, 1, 7'h06, "mid_1"); dig(0, 2, 7'h5B, "mid_2");
    areset("reset_mid_seq");
    def_unlock("default_restored");
    step(0, 0, 0, 0, 1, 7'h40, 0, 0, "enter_prog2");
    step(0, 1, 1, 0, 0, 7'h40, 0, 0, "prog2_w1");
    step(0, 1, 2, 0, 0, 7'h40, 0, 0, "prog2_w2");
    areset("reset_mid_prog");
    def_unlock("default_after_prog_reset");
    dig(1, 8'h05, 7'h6D, "b_5");
    step(1, 1, 8'h27, 0, 0, 7'h71, 0, 1, "b_fail_immediate");
    lock_wait(1, 3, "b_lockout3");
    dig(1, 8'h05, 7'h6D, "b_5b"); dig(1, 8'h09, 7'h6F, "b_9");
    step(1, 1, 8'h00, 1, 0, 7'h40, 0, 0, "b_limpa_wins");
    step(1, 1, 8'h00, 0, 0, 7'h71, 0, 1, "b_pos0_after_limpa");
    lock_wait(1, 3, "b_lockout3b");
    dig(1, 8'h05, 7'h6D, "b_u5"); dig(1, 8'h09, 7'h6F, "b_u9");
    step(1, 1, 8'h00, 0, 0, 7'h6D, 1, 0, "b_S");
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/seq_lock_checker.md
# seq_lock_checker

Parametrised digit-sequence lock checker for the keypad/lock datapath. It compares strobed digits against a stored code and tolerates up to MAX_ERR wrong entries. It reports success (S), partial success (P) or failure (F) on a 7-segment output, holds a timed lockout after failure, and lets the code be reprogrammed after a clean unlock. It is the generalised successor of the fixed 6-digit, 4-bit, one-error lock.

## Interface
- DIGIT_W, 4: digit width in bits.
- CODE_LEN, 6: number of digits in the code, ≥2.
- MAX_ERR, 1: wrong entries tolerated; entry MAX_ERR+1 fails.
- LOCKOUT_CYC, 16: lockout duration in clk cycles, ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- insere  in  1  digit strobe; one digit consumed per high cycle.
- entrada  in  DIGIT_W  digit value, sampled when insere=1.
- limpa  in  1  synchronous clear back to CHECK, pos=0, err=0.
- programa  in  1  request to reprogram; honoured only in DONE_S.
- display1  out  7  segments {g,f,e,d,c,b,a}, active-high.
- led  out  1  unlocked indicator.
- bloqueado  out  1  high during lockout.

## Operation
- Code register: CODE_LEN × DIGIT_W. Reset loads DEFAULT_CODE: 5,9,0,0,6,0 for CODE_LEN=6, otherwise the low digits of that pattern repeated.
- Counters: position pos (0..CODE_LEN-1) and error count err (0..MAX_ERR).
- States: CHECK, DONE_S, DONE_P, FAIL, PROG.
- CHECK, insere with entrada==code[pos]:
  - Display the digit (hex of the low 4 bits).
  - If pos==CODE_LEN-1, go to DONE_S when err==0, else DONE_P. Otherwise pos+1.
- CHECK, insere with a mismatch:
  - If err<MAX_ERR: err+1, pos unchanged, display E.
  - Otherwise go to FAIL, display F, load the lockout counter with LOCKOUT_CYC.
- DONE_S / DONE_P: display S / P, led=1. Held until limpa, or until programa in DONE_S. insere is ignored.
- FAIL: bloqueado=1, display F. The counter decrements every cycle. At 0 the block enters CHECK with pos=0, err=0, display dash. insere, limpa and programa are ignored.
- PROG: display dash, led=0, pos starts at 0. Each insere writes entrada to code[pos] and increments pos. After the CODE_LEN-th write, go to CHECK with pos=0, err=0. limpa aborts: written digits are kept, unwritten digits are unchanged.
- Priority within one cycle: reset > FAIL lockout > limpa > programa > insere.

## Timing
- All outputs are registered. An insere/limpa/programa sampled at edge N is visible on outputs after edge N, i.e. one cycle latency.
- Back-to-back insere on consecutive cycles is supported, one digit per cycle.
- Reset values: display1=7'h40 (dash), led=0, bloqueado=0, state CHECK, pos=0, err=0, code=DEFAULT_CODE.
- Reset asserted mid-sequence, mid-lockout or mid-program restores all reset values immediately (asynchronous) and discards any programmed code.
- bloqueado is high for exactly LOCKOUT_CYC cycles. CHECK accepts insere on the cycle after bloqueado falls.
- Segment constants: S=7'h6D, P=7'h73, F=7'h71, E=7'h79, dash=7'h40, digits 0-F standard hex.

## Structure
- Package lock_pkg holds:
  - the state enum;
  - the segment constants (S, P, F, E, dash);
  - the DEFAULT_CODE pattern;
  - the err width function $clog2(MAX_ERR+1), minimum 1.
- Sub-module seg7_hex: combinational 4-bit to 7-segment decoder used for digit display. Letter codes are muxed in the parent.

## Test plan
- Defaults, entries 5,9,0,0,6,0 -> displays 6D/0x6D sequence of digit codes ending in S (7'h6D), led=1, bloqueado=0.
- Entries 5,8,9,0,0,6,0 -> E (7'h79) after 8, final P (7'h73), led=1.
- Entries 5,8,8 -> F (7'h71) after the second 8. bloqueado=1 for exactly 16 cycles. insere during lockout is ignored. Then dash, pos=0.
- After S, programa then 1,2,3,4,5,6 -> CHECK. Entries 5,9,0,0,6,0 then fail (F after two errors). Entries 1,2,3,4,5,6 -> S.
- Reset driven low mid-sequence (after 5,9) and mid-program -> outputs immediately dash/0/0. Code reverts to 5,9,0,0,6,0.
- Parameter set DIGIT_W=8, CODE_LEN=3, MAX_ERR=0, LOCKOUT_CYC=3: one wrong digit -> F immediately, bloqueado for 3 cycles. limpa with insere in the same cycle -> limpa wins, pos=0.
